add7_stream_accumulator: RTL and testbench

//   Sequential front/back stage around the 7-bit adder ADD_7_bit. Accepts a start

---
 rtl/alu_pkg.sv | 20 ++
 rtl/ADD_7_bit.sv | 12 +
 rtl/add7_stream_accumulator.sv | 136 +++++++++++++
 tb/tb_add7_stream_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ADD_7_bit stream accumulator: operand width,
// FSM state encoding and the carry-counter saturation helper.
package alu_pkg;

    // Operand/sum width fixed by the ADD_7_bit adder.
    localparam int WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest value a cc_w-bit carry counter holds; reaching it arms the
    // sticky overflow flag on the next attempted increment.
    function automatic int sat_value(input int cc_w);
        return (1 << cc_w) - 1;
    endfunction

endpackage

// File: rtl/ADD_7_bit.sv
// Plain 7-bit ripple adder: sum is the wrapped result, carry the bit that
// falls off the top.
module ADD_7_bit (
    input  logic [6:0] a,
    input  logic [6:0] b,
    output logic [6:0] sum,
    output logic       carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add7_stream_accumulator.sv
// Accumulates a start-announced number of 7-bit operands from a valid/ready
// stream through one ADD_7_bit, then offers the wrapped sum, the number of
// adder carry-outs and a sticky saturation flag on a valid/ready result port.
module add7_stream_accumulator
    import alu_pkg::*;
#(
    parameter int WIDTH = 7,   // only 7 works: the adder is fixed-width
    parameter int CNT_W = 4,
    parameter int CC_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CC_W-1:0]  out_carry_cnt,
    output logic             out_ovf
);

    localparam logic [CC_W-1:0] CC_MAX = CC_W'(sat_value(CC_W));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CC_W-1:0]  carry_cnt_q, carry_cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             start_accept;
    logic             in_hs;

    ADD_7_bit u_add (
        .a     (acc_q),
        .b     (in_data),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign start_accept = (state_q == ST_IDLE) && start;
    assign in_hs        = in_valid && in_ready;

    // State register; a low rst_n at the edge aborts any job in progress.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values
        // regardless of block ordering.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> ACC/DONE on start, ACC -> DONE on the last
    // operand, DONE -> IDLE once the sink takes the result.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and a latch cannot be inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC: begin
                if (in_hs && (remaining_q == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake/status outputs decoded purely from the state register.
    always_comb begin
        busy      = (state_q == ST_ACC) || (state_q == ST_DONE);
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath next-state: clear on accepted start, accumulate on handshake.
    always_comb begin
        acc_d       = acc_q;
        remaining_d = remaining_q;
        carry_cnt_d = carry_cnt_q;
        ovf_d       = ovf_q;
        if (start_accept) begin
            acc_d       = '0;
            remaining_d = len;
            carry_cnt_d = '0;
            ovf_d       = 1'b0;
        end else if (in_hs) begin
            acc_d       = add_sum;
            remaining_d = remaining_q - CNT_W'(1);
            if (add_carry) begin
                if (carry_cnt_q == CC_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    carry_cnt_d = carry_cnt_q + CC_W'(1);
                end
            end
        end
    end

    // Datapath registers; they hold their values through IDLE and DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            remaining_q <= '0;
            carry_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            carry_cnt_q <= carry_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_sum       = acc_q;
    assign out_carry_cnt = carry_cnt_q;
    assign out_ovf       = ovf_q;

endmodule

// File: tb/tb_add7_stream_accumulator.sv
// Bench for add7_stream_accumulator: two instances (CC_W=4 and CC_W=2) share
// every input so saturation is exercised alongside normal accumulation.
module tb_add7_stream_accumulator;

    localparam int WIDTH  = 7;
    localparam int CNT_W  = 4;
    localparam int CC_W_A = 4;
    localparam int CC_W_B = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;

    logic              busy_a, in_ready_a, out_valid_a, ovf_a;
    logic [WIDTH-1:0]  sum_a;
    logic [CC_W_A-1:0] cc_a;
    logic              busy_b, in_ready_b, out_valid_b, ovf_b;
    logic [WIDTH-1:0]  sum_b;
    logic [CC_W_B-1:0] cc_b;

    add7_stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CC_W(CC_W_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(sum_a),
        .out_carry_cnt(cc_a), .out_ovf(ovf_a)
    );

    add7_stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CC_W(CC_W_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(sum_b),
        .out_carry_cnt(cc_b), .out_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int data[16];
        int exp_sum;
        int exp_cc_a;
        int exp_ovf_a;
        int exp_cc_b;
        int exp_ovf_b;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int es, input int cca, input int ova,
                                input int ccb, input int ovb);
        check({tag, " sum_a"}, 32'(sum_a), es);
        check({tag, " sum_b"}, 32'(sum_b), es);
        check({tag, " cc_a"}, 32'(cc_a), cca);
        check({tag, " ovf_a"}, 32'(ovf_a), ova);
        check({tag, " cc_b"}, 32'(cc_b), ccb);
        check({tag, " ovf_b"}, 32'(ovf_b), ovb);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, 32'({busy_a, busy_b}), 0);
        check({tag, " in_ready"}, 32'({in_ready_a, in_ready_b}), 0);
        check({tag, " out_valid"}, 32'({out_valid_a, out_valid_b}), 0);
        check_result(tag, 0, 0, 0, 0, 0);
    endtask

    // Run one complete job. gap_max bounds random in_valid gaps per operand;
    // stall is the exact number of cycles out_ready stays low in DONE; when
    // poke_start is set, start is held high through the stall and the exit.
    task automatic do_job(input string tag, input int l, input int d[16], input int gap_max,
                          input int stall, input bit poke_start, input int es, input int cca,
                          input int ova, input int ccb, input int ovb);
        start = 1'b1;
        len   = CNT_W'(l);
        tick();
        start = 1'b0;
        len   = CNT_W'($urandom);
        if (l == 0) begin
            check({tag, " len0 in_ready"}, 32'(in_ready_a), 0);
        end
        for (int i = 0; i < l; i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                in_data = WIDTH'($urandom);
                check({tag, " gap out_valid"}, 32'(out_valid_a), 0);
                tick();
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(d[i]);
            check({tag, " in_ready"}, 32'({in_ready_a, in_ready_b}), 32'b11);
            tick();
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom);
        end
        check({tag, " latency out_valid"}, 32'({out_valid_a, out_valid_b}), 32'b11);
        check({tag, " done busy"}, 32'(busy_a), 1);
        check_result(tag, es, cca, ova, ccb, ovb);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (poke_start) begin
                start = 1'b1;
                len   = CNT_W'(7);
            end
            tick();
            check({tag, " stall out_valid"}, 32'(out_valid_a), 1);
            check({tag, " stall in_ready"}, 32'(in_ready_a), 0);
            check({tag, " stall sum"}, 32'(sum_a), es);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, " exit out_valid"}, 32'({out_valid_a, out_valid_b}), 0);
        check({tag, " exit busy"}, 32'({busy_a, busy_b}), 0);
        check({tag, " held sum"}, 32'(sum_a), es);
    endtask

    vec_t vecs[5];

    initial begin
        int d[16];
        int s;
        int c;
        int l;

        vecs[0] = '{3,  '{0:10, 1:20, 2:30, default:0}, 60, 0, 0, 0, 0};
        vecs[1] = '{2,  '{0:100, 1:100, default:0},     72, 1, 0, 1, 0};
        vecs[2] = '{0,  '{default:0},                    0, 0, 0, 0, 0};
        vecs[3] = '{5,  '{0:127, 1:127, 2:127, 3:127, 4:127, default:0}, 123, 4, 0, 3, 1};
        vecs[4] = '{4,  '{0:64, 1:64, 2:64, 3:64, default:0}, 0, 2, 0, 2, 0};

        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_job($sformatf("vec%0d", i), vecs[i].len, vecs[i].data, 0, 0, 1'b0,
                   vecs[i].exp_sum, vecs[i].exp_cc_a, vecs[i].exp_ovf_a,
                   vecs[i].exp_cc_b, vecs[i].exp_ovf_b);
        end

        // Result held in DONE for 5 cycles with start pulsed; start also high
        // in the exit cycle, which must not launch a new job.
        do_job("done_hold", 3, vecs[0].data, 0, 5, 1'b1, 60, 0, 0, 0, 0);

        // Reset after 2 of 4 operands discards everything.
        start = 1'b1;
        len   = CNT_W'(4);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = WIDTH'(50);
        tick();
        in_data  = WIDTH'(60);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_idle_zero("midreset");
        rst_n = 1'b1;
        tick();
        check({"midreset after"}, 32'(busy_a), 0);
        d = '{0:5, default:0};
        do_job("post_reset", 1, d, 0, 0, 1'b0, 5, 0, 0, 0, 0);

        // Random jobs: the expected sum is the plain total mod 128, and the
        // number of adder carries is how many times the total wrapped.
        for (int j = 0; j < 40; j++) begin
            l = int'($urandom_range(15, 0));
            s = 0;
            d = '{default:0};
            for (int i = 0; i < l; i++) begin
                d[i] = int'($urandom_range(127, 0));
                s += d[i];
            end
            c = s / 128;
            do_job($sformatf("rand%0d", j), l, d, 2, int'($urandom_range(3, 0)), 1'b0,
                   s % 128,
                   (c > 15) ? 15 : c, (c > 15) ? 1 : 0,
                   (c > 3) ? 3 : c, (c > 3) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
